// File: rtl/router_pkg.sv
// Shared router types and width helpers used by the per-output allocators and FIFOs.
package router_pkg;

  typedef enum logic {IDLE, LOCK} state_t;

  localparam int DEFAULT_DEPTH = 4;

  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_w(input int d);
    return $clog2(d + 1);
  endfunction

endpackage

// File: rtl/port_alloc_ctrl_rr_pick.sv
// Rotating priority encoder: first set request at or after ptr, wrapping modulo NREQ.
module rr_pick #(
  parameter int NREQ = 2,
  parameter int SW   = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [SW-1:0]   ptr,
  output logic [SW-1:0]   idx,
  output logic            found
);

  int w_off;
  int w_best;

  // Smallest rotational distance from ptr wins.
  always_comb begin
    idx    = '0;
    found  = 1'b0;
    w_best = NREQ;
    w_off  = 0;
    for (int i = 0; i < NREQ; i++) begin
      w_off = (i >= int'(ptr)) ? (i - int'(ptr)) : (i + NREQ - int'(ptr));
      if (req[i] && (w_off < w_best)) begin
        w_best = w_off;
        idx    = SW'(i);
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/port_alloc_ctrl.sv
// Per-output allocator: round-robin with packet locking and downstream credit tracking.
//   state | meaning
//   IDLE  | no owner; pick next requester starting at ptr
//   LOCK  | owner holds the output until its tail flit is forwarded
module port_alloc_ctrl
  import router_pkg::*;
#(
  parameter  int NREQ  = 2,
  parameter  int DEPTH = DEFAULT_DEPTH,
  localparam int SW    = sel_w(NREQ),
  localparam int CW    = cnt_w(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] tail,
  input  logic            credit_in,
  output logic [NREQ-1:0] gnt,
  output logic [SW-1:0]   sel,
  output logic            fwd,
  output logic [CW-1:0]   credit_cnt,
  output logic            busy,
  output logic            cred_err
);

  state_t          r_state;
  logic [SW-1:0]   r_ptr;
  logic [SW-1:0]   r_owner;
  logic [CW-1:0]   r_cnt;
  logic            r_cred_err;

  logic [SW-1:0]   w_pick;
  logic            w_found;
  logic [NREQ-1:0] w_gnt;
  logic            w_fwd;

  rr_pick #(.NREQ(NREQ), .SW(SW)) u_rr_pick (
    .req   (req),
    .ptr   (r_ptr),
    .idx   (w_pick),
    .found (w_found)
  );

  always_comb begin
    w_gnt = '0;
    if ((r_state == LOCK) && req[r_owner] && (r_cnt != '0))
      w_gnt[r_owner] = 1'b1;
  end

  assign w_fwd = |w_gnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_ptr      <= '0;
      r_owner    <= '0;
      r_cnt      <= CW'(DEPTH);
      r_cred_err <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_owner <= w_pick;
            r_state <= LOCK;
          end
        end
        LOCK: begin
          if (w_fwd && tail[r_owner]) begin
            r_state <= IDLE;
            r_ptr   <= (r_owner == SW'(NREQ - 1)) ? '0 : r_owner + SW'(1);
          end
        end
        default: r_state <= IDLE;
      endcase

      // A returned credit with nothing to absorb it at full count is a protocol error.
      if (credit_in && !w_fwd) begin
        if (r_cnt == CW'(DEPTH))
          r_cred_err <= 1'b1;
        else
          r_cnt <= r_cnt + CW'(1);
      end else if (!credit_in && w_fwd) begin
        r_cnt <= r_cnt - CW'(1);
      end
    end
  end

  assign gnt        = w_gnt;
  assign fwd        = w_fwd;
  assign busy       = (r_state == LOCK);
  assign sel        = (r_state == LOCK) ? r_owner : '0;
  assign credit_cnt = r_cnt;
  assign cred_err   = r_cred_err;

endmodule

// File: tb/tb_port_alloc_ctrl.sv
// Directed bench for port_alloc_ctrl (NREQ=2, DEPTH=4) with a per-cycle expectation queue.
module tb_port_alloc_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req;
  logic [1:0] tail;
  logic       credit_in;
  logic [1:0] gnt;
  logic       sel;
  logic       fwd;
  logic [2:0] credit_cnt;
  logic       busy;
  logic       cred_err;

  typedef struct {
    string      tag;
    logic [8:0] v;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  port_alloc_ctrl #(.NREQ(2), .DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .tail       (tail),
    .credit_in  (credit_in),
    .gnt        (gnt),
    .sel        (sel),
    .fwd        (fwd),
    .credit_cnt (credit_cnt),
    .busy       (busy),
    .cred_err   (cred_err)
  );

  always #5 clk = ~clk;

  // Observed vector layout: {gnt[1:0], sel, fwd, busy, credit_cnt[2:0], cred_err}
  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_t       e;
      logic [8:0] obs;
      e   = sb.pop_front();
      obs = {gnt, sel, fwd, busy, credit_cnt, cred_err};
      n_tests++;
      assert (obs === e.v) else begin
        n_fail++;
        $error("FAIL %s observed gnt/sel/fwd/busy/cnt/err=%b expected=%b", e.tag, obs, e.v);
      end
    end
  end

  task automatic step(input logic rb, input logic [1:0] r, input logic [1:0] t, input logic ci,
                      input string tag, input logic [1:0] g, input logic s, input logic b,
                      input logic [2:0] c, input logic e);
    exp_t x;
    rst       = rb;
    req       = r;
    tail      = t;
    credit_in = ci;
    x.tag     = tag;
    x.v       = {g, s, |g, b, c, e};
    sb.push_back(x);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; req = 2'b00; tail = 2'b00; credit_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    //     rst req    tail   ci  tag            gnt    sel  busy cnt   err
    step(0, 2'b00, 2'b00, 0, "reset",       2'b00, 0, 0, 3'd4, 0);

    // Alternating single-flit packets drain credits 4..0, then owner 0 locks without credit.
    step(1, 2'b11, 2'b11, 0, "alt_idle0",   2'b00, 0, 0, 3'd4, 0);
    step(1, 2'b11, 2'b11, 0, "alt_g0_a",    2'b01, 0, 1, 3'd4, 0);
    step(1, 2'b11, 2'b11, 0, "alt_idle1",   2'b00, 0, 0, 3'd3, 0);
    step(1, 2'b11, 2'b11, 0, "alt_g1_a",    2'b10, 1, 1, 3'd3, 0);
    step(1, 2'b11, 2'b11, 0, "alt_idle2",   2'b00, 0, 0, 3'd2, 0);
    step(1, 2'b11, 2'b11, 0, "alt_g0_b",    2'b01, 0, 1, 3'd2, 0);
    step(1, 2'b11, 2'b11, 0, "alt_idle3",   2'b00, 0, 0, 3'd1, 0);
    step(1, 2'b11, 2'b11, 0, "alt_g1_b",    2'b10, 1, 1, 3'd1, 0);
    step(1, 2'b11, 2'b11, 0, "alt_idle4",   2'b00, 0, 0, 3'd0, 0);
    step(1, 2'b11, 2'b11, 0, "nocred_a",    2'b00, 0, 1, 3'd0, 0);
    step(1, 2'b11, 2'b11, 0, "nocred_b",    2'b00, 0, 1, 3'd0, 0);

    // One credit releases exactly one flit.
    step(1, 2'b11, 2'b00, 1, "cred_pulse",  2'b00, 0, 1, 3'd0, 0);
    step(1, 2'b11, 2'b00, 0, "one_flit",    2'b01, 0, 1, 3'd1, 0);
    step(1, 2'b11, 2'b00, 0, "back_to_0",   2'b00, 0, 1, 3'd0, 0);

    // Simultaneous credit and forward leave the count unchanged.
    step(1, 2'b11, 2'b00, 1, "refill_a",    2'b00, 0, 1, 3'd0, 0);
    step(1, 2'b11, 2'b00, 1, "simul_1",     2'b01, 0, 1, 3'd1, 0);
    step(1, 2'b00, 2'b00, 1, "hold_noreq",  2'b00, 0, 1, 3'd1, 0);
    step(1, 2'b11, 2'b00, 1, "simul_2",     2'b01, 0, 1, 3'd2, 0);
    step(1, 2'b11, 2'b11, 1, "simul_tail",  2'b01, 0, 1, 3'd2, 0);

    // Owner 1 sends a 3-flit packet while input 0 keeps requesting; input 0 wins afterwards.
    step(1, 2'b11, 2'b00, 1, "mf_idle",     2'b00, 0, 0, 3'd2, 0);
    step(1, 2'b11, 2'b00, 0, "mf_flit1",    2'b10, 1, 1, 3'd3, 0);
    step(1, 2'b11, 2'b00, 0, "mf_flit2",    2'b10, 1, 1, 3'd2, 0);
    step(1, 2'b11, 2'b10, 0, "mf_flit3",    2'b10, 1, 1, 3'd1, 0);
    step(1, 2'b11, 2'b00, 0, "mf_gap",      2'b00, 0, 0, 3'd0, 0);
    step(1, 2'b11, 2'b00, 1, "mf_next_own0",2'b00, 0, 1, 3'd0, 0);
    step(1, 2'b11, 2'b11, 0, "mf_next_g0",  2'b01, 0, 1, 3'd1, 0);

    // Refill to DEPTH and overflow the credit counter.
    step(1, 2'b00, 2'b00, 1, "fill_0",      2'b00, 0, 0, 3'd0, 0);
    step(1, 2'b00, 2'b00, 1, "fill_1",      2'b00, 0, 0, 3'd1, 0);
    step(1, 2'b00, 2'b00, 1, "fill_2",      2'b00, 0, 0, 3'd2, 0);
    step(1, 2'b00, 2'b00, 1, "fill_3",      2'b00, 0, 0, 3'd3, 0);
    step(1, 2'b00, 2'b00, 1, "ovf_pulse",   2'b00, 0, 0, 3'd4, 0);
    step(1, 2'b00, 2'b00, 0, "err_sticky1", 2'b00, 0, 0, 3'd4, 1);
    step(1, 2'b00, 2'b00, 0, "err_sticky2", 2'b00, 0, 0, 3'd4, 1);

    // Reset mid-packet with owner 1 locked and one credit left.
    step(1, 2'b10, 2'b00, 0, "mp_idle",     2'b00, 0, 0, 3'd4, 1);
    step(1, 2'b10, 2'b00, 0, "mp_f1",       2'b10, 1, 1, 3'd4, 1);
    step(1, 2'b10, 2'b00, 0, "mp_f2",       2'b10, 1, 1, 3'd3, 1);
    step(1, 2'b10, 2'b00, 0, "mp_f3",       2'b10, 1, 1, 3'd2, 1);
    step(0, 2'b10, 2'b00, 0, "mp_rst_cyc",  2'b10, 1, 1, 3'd1, 1);
    step(1, 2'b11, 2'b11, 0, "post_rst",    2'b00, 0, 0, 3'd4, 0);
    step(1, 2'b11, 2'b11, 0, "post_rst_p0", 2'b01, 0, 1, 3'd4, 0);
    step(1, 2'b00, 2'b00, 0, "post_idle",   2'b00, 0, 0, 3'd3, 0);

    for (int k = 0; k < 5 && sb.size() != 0; k++) @(posedge clk);
    n_tests++;
    assert (sb.size() == 0) else begin
      n_fail++;
      $error("FAIL drain observed %0d pending expected 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/port_alloc_ctrl.md
Name: port_alloc_ctrl

Overview:
- Per-output-port allocator for the star router: one instance per crossbar output.
- Shares the output between NREQ input FIFOs using round-robin arbitration with packet locking.
- Tracks downstream buffer credits so no flit is forwarded into a full neighbour.
- Drives the crossbar select and the grants that feed the FIFO read enables.

Parameters:
NREQ, 2, number of requesting input ports (2..16)
DEPTH, 4, downstream buffer depth; initial and maximum credit count
CW, $clog2(DEPTH+1), credit counter width (derived, not overridable)
SW, $clog2(NREQ) min 1, select width (derived)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous active-low reset
req  in  NREQ  req[i]=1: input i has a flit at its FIFO head routed to this output
tail  in  NREQ  tail[i]=1: input i's head flit is the packet's last flit; qualified by req[i]
credit_in  in  1  one downstream slot freed this cycle
gnt  out  NREQ  one-hot; gnt[i]=1: input i's head flit is forwarded this cycle (FIFO pops it)
sel  out  SW  binary index of current owner; crossbar select
fwd  out  1  a flit crosses this output this cycle (= |gnt)
credit_cnt  out  CW  current credit count
busy  out  1  port locked to an owner
cred_err  out  1  sticky: credit_in received while credit_cnt==DEPTH

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-low. Everything samples on the rising clk edge.
- Reset (rst==0 at an edge) sets:
  - state IDLE, ptr=0, owner=0, credit_cnt=DEPTH, cred_err=0.
  - Consequently gnt=0, fwd=0, sel=0, busy=0.
  - Reset mid-packet abandons the lock and restores full credits without exception.
- States:
  - IDLE: if any req bit is set, rr_pick selects the first set req index starting at ptr and wrapping modulo NREQ. That index is registered as owner, and the state moves to LOCK. Credits are not required to lock. No grant is issued in IDLE.
  - LOCK: busy=1, sel=owner. gnt[owner]=req[owner] && (credit_cnt!=0); all other gnt bits are 0. gnt and fwd are combinational from registered state, req and credit_cnt.
- Transition out of LOCK: on an edge with fwd=1 and tail[owner]=1, the state goes to IDLE and ptr becomes (owner+1) mod NREQ.
- Lock holding: if req[owner] drops or credits are 0, the state stays in LOCK; other requesters never interleave mid-packet.
- Latency:
  - req asserted at edge t in IDLE → owner registered at t, gnt at cycle t+1.
  - Minimum 1 idle cycle between packets on a port (LOCK→IDLE→LOCK).
  - Single-flit packet (tail with first flit): 1 grant cycle.
- Credits: next credit_cnt = credit_cnt + credit_in − fwd.
  - Simultaneous credit_in and fwd: count unchanged.
  - fwd is impossible at 0, so no underflow.
  - credit_in at DEPTH without fwd: count holds at DEPTH and cred_err sets; it clears only on reset.
- Fairness: the pointer advances only on packet completion. With all inputs continuously requesting, owners rotate 0,1,…,NREQ−1,0.
- Requester IDs beyond NREQ−1 never appear; sel is 0 in IDLE.

Decomposition:
- Shared package router_pkg holds:
  - state enum {IDLE, LOCK};
  - localparam helpers for clog2-based widths;
  - default DEPTH, shared with the FIFO depth constant.
- Sub-module rr_pick: combinational rotating priority encoder (req, ptr → idx, found), reused by future multi-output allocators.

Test Plan:
- After reset, credit_in=0, req=2'b11 held with tail=2'b11 → owner 0 granted at cycle 2, then owner 1, alternating 0,1,0,1; one idle cycle between grants; credit_cnt goes 4,3,2,1,0, then gnt stays 0 and busy=1.
- Owner 1 sends a 3-flit packet (tail only on flit 3) while req[0]=1 throughout → gnt=2'b10 for 3 cycles, no gnt[0] until after IDLE; ptr becomes 0 and input 0 wins next.
- credit_cnt=0 in LOCK, then a credit_in pulse → exactly one flit forwarded next cycle; credit_cnt goes 0→1→0.
- credit_cnt=2, fwd=1 and credit_in=1 in the same cycle → credit_cnt stays 2.
- credit_in pulsed at credit_cnt=4 with no traffic → credit_cnt stays 4 and cred_err=1 until reset.
- rst=0 mid-packet (busy=1, credit_cnt=1) → next edge: busy=0, gnt=0, sel=0, credit_cnt=4, cred_err=0, ptr=0.
